// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared widths, state encoding and depth-width helper for pc_sequencer
package pc_seq_pkg;

  localparam int PC_W        = 8;
  localparam int STACK_DEPTH = 4;

  typedef enum logic {RUN, HALTED} seqState_t;

  // One extra bit so a completely full stack (depth == STACK_DEPTH) is representable.
  function automatic int depthW(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - LIFO return-address stack; push on full and pop on empty are ignored
module pc_ret_stack #(
  parameter int PC_W        = pc_seq_pkg::PC_W,
  parameter int STACK_DEPTH = pc_seq_pkg::STACK_DEPTH
) (
  input  logic                                       clk,
  input  logic                                       rstN,
  input  logic                                       push,
  input  logic                                       pop,
  input  logic [PC_W-1:0]                            pushData,
  output logic [PC_W-1:0]                            topData,
  output logic [pc_seq_pkg::depthW(STACK_DEPTH)-1:0] depth,
  output logic                                       full,
  output logic                                       empty
);
  import pc_seq_pkg::*;

  localparam int DW = depthW(STACK_DEPTH);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [AW-1:0]   wrIdx;
  logic [AW-1:0]   rdIdx;

  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign wrIdx   = AW'(depth);
  assign rdIdx   = AW'(depth - DW'(1));
  assign topData = mem[rdIdx];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

  // Entries are not reset: contents above the depth pointer are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wrIdx] <= pushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with call/return stack and RUN/HALTED FSM
// Define PCSEQ_ERR_FLAGS_EN to build the sticky ovfErr/unfErr flags and errClear.
module pc_sequencer #(
  parameter int PC_W        = pc_seq_pkg::PC_W,
  parameter int STACK_DEPTH = pc_seq_pkg::STACK_DEPTH
) (
  input  logic                                       clk,
  input  logic                                       rstN,
  input  logic                                       stall,
  input  logic                                       jump,
  input  logic                                       call,
  input  logic                                       ret,
  input  logic                                       halt,
  input  logic                                       resume,
  input  logic [PC_W-1:0]                            target,
  input  logic                                       errClear,
  output logic [PC_W-1:0]                            pcCount,
  output logic [pc_seq_pkg::depthW(STACK_DEPTH)-1:0] depth,
  output logic                                       halted,
  output logic                                       ovfErr,
  output logic                                       unfErr
);
  import pc_seq_pkg::*;

  seqState_t       state, nextState;
  logic [PC_W-1:0] nextPc, pcPlus1, topData;
  logic            push, pop, full, empty;
  logic            setOvf, setUnf, active;

  assign pcPlus1 = pcCount + PC_W'(1);
  assign active  = (state == RUN) && !stall;
  assign halted  = (state == HALTED);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= RUN;
      pcCount <= '0;
    end else begin
      state   <= nextState;
      pcCount <= nextPc;
    end
  end

  always_comb begin
    nextState = state;
    nextPc    = pcCount;
    push      = 1'b0;
    pop       = 1'b0;
    setOvf    = 1'b0;
    setUnf    = 1'b0;
    if (state == HALTED) begin
      if (resume) nextState = RUN;
    end else if (!stall) begin
      if (ret) begin
        if (!empty) begin
          pop    = 1'b1;
          nextPc = topData;
        end else begin
          nextPc = pcPlus1;
          setUnf = 1'b1;
        end
      end else if (call) begin
        nextPc = target;
        if (!full) push = 1'b1;
        else       setOvf = 1'b1;
      end else if (jump) begin
        nextPc = target;
      end else if (halt) begin
        nextState = HALTED;
      end else begin
        nextPc = pcPlus1;
      end
    end
  end

  pc_ret_stack #(
    .PC_W       (PC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) uStack (
    .clk     (clk),
    .rstN    (rstN),
    .push    (push),
    .pop     (pop),
    .pushData(pcPlus1),
    .topData (topData),
    .depth   (depth),
    .full    (full),
    .empty   (empty)
  );

`ifdef PCSEQ_ERR_FLAGS_EN
  // Flags only move on active cycles; a set in the same cycle as errClear wins.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovfErr <= 1'b0;
      unfErr <= 1'b0;
    end else if (active) begin
      ovfErr <= setOvf | (ovfErr & ~errClear);
      unfErr <= setUnf | (unfErr & ~errClear);
    end
  end
`else
  logic unusedFlagInputs;
  assign unusedFlagInputs = errClear ^ setOvf ^ setUnf ^ active;
  assign ovfErr = 1'b0;
  assign unfErr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with a queue-based reference model
module tb_pc_sequencer;

`ifdef PCSEQ_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk = 1'b0, rstN = 1'b0;
  logic       stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic       halt = 1'b0, resume = 1'b0, errClear = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] pcCount;
  logic [2:0] depth;
  logic       halted, ovfErr, unfErr;

  pc_sequencer dut (
    .clk(clk), .rstN(rstN), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .halt(halt), .resume(resume), .target(target), .errClear(errClear),
    .pcCount(pcCount), .depth(depth), .halted(halted), .ovfErr(ovfErr), .unfErr(unfErr)
  );

  always #5 clk = ~clk;

  int nVec = 0, nFail = 0;
  bit running = 1'b0;

  int mPc;
  int mStack[$];
  bit mHalt, mOvf, mUnf, mSo, mSu;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPc = 0; mStack.delete(); mHalt = 0; mOvf = 0; mUnf = 0;
    end else if (mHalt) begin
      if (resume) mHalt = 0;
    end else if (!stall) begin
      mSo = 0; mSu = 0;
      if (ret) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin mPc = (mPc + 1) % 256; mSu = 1; end
      end else if (call) begin
        if (mStack.size() < 4) mStack.push_back((mPc + 1) % 256);
        else mSo = 1;
        mPc = int'(target);
      end else if (jump) mPc = int'(target);
      else if (halt) mHalt = 1;
      else mPc = (mPc + 1) % 256;
      if (errClear) begin mOvf = 0; mUnf = 0; end
      if (mSo) mOvf = 1;
      if (mSu) mUnf = 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      check("model pc", 32'(pcCount), 32'(mPc));
      check("model depth", 32'(depth), 32'(mStack.size()));
      check("model halted", 32'(halted), 32'(mHalt));
      check("model ovfErr", 32'(ovfErr), 32'(FLAGS_ON & mOvf));
      check("model unfErr", 32'(unfErr), 32'(FLAGS_ON & mUnf));
    end
  end

  // Inputs are set at a falling edge, held across one rising edge, then cleared.
  task automatic cmd(input bit j, c, r, h, res, s, ec, input logic [7:0] t);
    jump = j; call = c; ret = r; halt = h; resume = res; stall = s; errClear = ec; target = t;
    @(negedge clk);
    jump = 0; call = 0; ret = 0; halt = 0; resume = 0; stall = 0; errClear = 0; target = 8'h00;
  endtask
  task automatic idle(input int n);
    repeat (n) cmd(0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask
  task automatic doJump(input logic [7:0] t); cmd(1, 0, 0, 0, 0, 0, 0, t); endtask
  task automatic doCall(input logic [7:0] t); cmd(0, 1, 0, 0, 0, 0, 0, t); endtask
  task automatic doRet();                     cmd(0, 0, 1, 0, 0, 0, 0, 8'h00); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    running = 1'b1;
    check("reset pc", 32'(pcCount), 32'h0);
    check("reset depth", 32'(depth), 32'h0);
    rstN = 1'b1;

    idle(5);
    check("idle pc5", 32'(pcCount), 32'h5);
    check("idle flags", 32'({ovfErr, unfErr}), 32'h0);

    doJump(8'h10);
    doCall(8'h40);
    check("call pc", 32'(pcCount), 32'h40);
    check("call depth", 32'(depth), 32'h1);
    idle(2);
    doRet();
    check("ret pc", 32'(pcCount), 32'h11);
    check("ret depth", 32'(depth), 32'h0);

    doCall(8'h50); doCall(8'h60); doCall(8'h70); doCall(8'h80);
    check("full depth", 32'(depth), 32'h4);
    doCall(8'h90);
    check("ovf pc", 32'(pcCount), 32'h90);
    check("ovf depth", 32'(depth), 32'h4);
    check("ovf flag", 32'(ovfErr), 32'(FLAGS_ON));
    doRet(); check("lifo 1", 32'(pcCount), 32'h71);
    doRet(); check("lifo 2", 32'(pcCount), 32'h61);
    doRet(); check("lifo 3", 32'(pcCount), 32'h51);
    doRet(); check("lifo 4", 32'(pcCount), 32'h12);
    doRet();
    check("unf pc", 32'(pcCount), 32'h13);
    check("unf flag", 32'(unfErr), 32'(FLAGS_ON));
    cmd(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check("clear flags", 32'({ovfErr, unfErr}), 32'h0);
    cmd(0, 0, 1, 0, 0, 0, 1, 8'h00);
    check("set wins", 32'(unfErr), 32'(FLAGS_ON));
    cmd(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check("clear again", 32'(pcCount), 32'h16);

    doJump(8'hFF);
    idle(1);
    check("wrap pc", 32'(pcCount), 32'h0);
    doJump(8'hFF);
    doCall(8'h30);
    doRet();
    check("wrap push", 32'(pcCount), 32'h0);

    doCall(8'hA0); doCall(8'hB0);
    cmd(0, 1, 1, 0, 0, 0, 0, 8'hC0);
    check("ret beats call pc", 32'(pcCount), 32'hA1);
    check("ret beats call depth", 32'(depth), 32'h1);
    cmd(0, 1, 0, 0, 0, 1, 0, 8'hD0);
    check("stall pc", 32'(pcCount), 32'hA1);
    check("stall depth", 32'(depth), 32'h1);
    doRet();
    check("stall ret", 32'(pcCount), 32'h1);

    doJump(8'h20);
    cmd(0, 0, 0, 1, 0, 0, 0, 8'h00);
    check("halt pc", 32'(pcCount), 32'h20);
    check("halt state", 32'(halted), 32'h1);
    repeat (3) doJump(8'h55);
    check("halt ignores jump", 32'(pcCount), 32'h20);
    cmd(0, 0, 0, 0, 1, 0, 0, 8'h00);
    check("resume pc", 32'(pcCount), 32'h20);
    check("resume state", 32'(halted), 32'h0);
    idle(1);
    check("resume inc", 32'(pcCount), 32'h21);
    cmd(0, 0, 0, 1, 0, 0, 0, 8'h00);
    #2 rstN = 1'b0;
    #1 check("async rst pc", 32'(pcCount), 32'h0);
    check("async rst state", 32'(halted), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    idle(1);
    check("post rst inc", 32'(pcCount), 32'h1);

    doCall(8'h44);
    #2 rstN = 1'b0; call = 1'b1; target = 8'h77;
    @(negedge clk);
    rstN = 1'b1; call = 1'b0; target = 8'h00;
    idle(1);
    check("mid-call rst pc", 32'(pcCount), 32'h1);
    check("mid-call rst depth", 32'(depth), 32'h0);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
